// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding, default width and counter sizing for the PISO transmitter.
package piso_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    localparam int DATA_W = 4;
    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction
endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: clear/enable bit counter with terminal-count flag at WIDTH-1.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      en,
    output logic [cnt_w(WIDTH)-1:0]   cnt,
    output logic                      tc
);
    localparam int CW = cnt_w(WIDTH);

    always_ff @(posedge clk) begin
        if (reset || clr) cnt <= '0;
        else if (en) cnt <= cnt + CW'(1);
    end

    assign tc = cnt == CW'(WIDTH - 1);
endmodule

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in serial-out transmitter with load/ready handshake and done pulse.
// Optional even-parity trailer bit enabled by defining PISO_SHIFT_TX_PARITY_EN.
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = DATA_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             x,
    output logic             valid,
    output logic             done
);
    localparam int CW = cnt_w(WIDTH);
`ifdef PISO_SHIFT_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    logic par;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    state_t          state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]   cnt;
    logic            tc;

    // cnt indexes the bit currently on x; it is held at zero outside SHIFT
    piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (state != SHIFT || tc),
        .en   (state == SHIFT),
        .cnt  (cnt),
        .tc   (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sreg  <= '0;
            ready <= 1'b1;
            x     <= 1'b0;
            valid <= 1'b0;
            done  <= 1'b0;
`ifdef PISO_SHIFT_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (load) begin
                    state <= SHIFT;
                    sreg  <= din;
                    x     <= MSB_FIRST ? din[WIDTH-1] : din[0];
                    valid <= 1'b1;
                    ready <= 1'b0;
                    done  <= 1'b0;
`ifdef PISO_SHIFT_TX_PARITY_EN
                    par   <= ^din;
`endif
                end
                SHIFT: if (tc) begin
`ifdef PISO_SHIFT_TX_PARITY_EN
                    state <= PARITY;
                    x     <= par;
                    done  <= 1'b1;
`else
                    state <= IDLE;
                    x     <= 1'b0;
                    valid <= 1'b0;
                    ready <= 1'b1;
                    done  <= 1'b0;
`endif
                end else begin
                    sreg <= MSB_FIRST ? sreg << 1 : sreg >> 1;
                    x    <= MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
                    done <= !PAR_EN && cnt == CW'(WIDTH - 2);
                end
`ifdef PISO_SHIFT_TX_PARITY_EN
                PARITY: begin
                    state <= IDLE;
                    x     <= 1'b0;
                    valid <= 1'b0;
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx: MSB-first and LSB-first transmitters checked every cycle against a frame-queue model.
module tb_piso_shift_tx;
    localparam int W = 4;
`ifdef PISO_SHIFT_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic load = 1'b0;
    logic [W-1:0] din = '0;
    logic rdy_m, x_m, v_m, d_m;
    logic rdy_l, x_l, v_l, d_l;

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .load(load), .din(din),
        .ready(rdy_m), .x(x_m), .valid(v_m), .done(d_m)
    );
    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .load(load), .din(din),
        .ready(rdy_l), .x(x_l), .valid(v_l), .done(d_l)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: an accepted word becomes a queue of per-cycle expected outputs
    typedef struct packed {logic xm; logic xl; logic dn;} ent_t;
    ent_t q[$];
    ent_t ent;
    logic e_ready = 1'b1, e_valid = 1'b0, e_xm = 1'b0, e_xl = 1'b0, e_done = 1'b0;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            chk_en = 1'b1;
        end else if (e_ready && load) begin
            for (int i = 0; i < W; i++)
                q.push_back('{din[W-1-i], din[i], (i == W-1) && !PAR});
            if (PAR) q.push_back('{^din, ^din, 1'b1});
        end
        if (!reset && q.size() > 0) begin
            ent = q.pop_front();
            e_ready = 1'b0; e_valid = 1'b1;
            e_xm = ent.xm; e_xl = ent.xl; e_done = ent.dn;
        end else begin
            e_ready = 1'b1; e_valid = 1'b0;
            e_xm = 1'b0; e_xl = 1'b0; e_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready_msb", rdy_m, e_ready);
            chk("valid_msb", v_m, e_valid);
            chk("x_msb", x_m, e_xm);
            chk("done_msb", d_m, e_done);
            chk("ready_lsb", rdy_l, e_ready);
            chk("valid_lsb", v_l, e_valid);
            chk("x_lsb", x_l, e_xl);
            chk("done_lsb", d_l, e_done);
        end
    end

    // receiver stand-ins: MSB-first shifts in at bit 0, LSB-first at bit W-1
    logic [W-1:0] rx_m, rx_l;
    int nvalid, ndone;
    logic last_x;
    always @(negedge clk) begin
        if (v_m) begin
            if (nvalid < W) begin
                rx_m = {rx_m[W-2:0], x_m};
                rx_l = {x_l, rx_l[W-1:1]};
            end
            nvalid++;
            if (d_m) begin
                ndone++;
                last_x = x_m;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_obs();
        rx_m = '0; rx_l = '0; nvalid = 0; ndone = 0; last_x = 1'b0;
    endtask

    task automatic go(input logic [W-1:0] d);
        @(negedge clk);
        load = 1'b1; din = d;
        @(negedge clk);
        load = 1'b0; din = W'($urandom);
    endtask

    initial begin
        clr_obs();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(3);
        chk("idle_ready", rdy_m, 1'b1);
        chk("idle_valid", v_m, 1'b0);

        clr_obs();
        go(4'b1011);
        cyc(W + 3);
        chk("f1011_msb_rx", rx_m, 4'b1011);
        chk("f1011_lsb_rx", rx_l, 4'b1011);
        chk("f1011_done_cnt", ndone, 1);
        chk("f1011_len", nvalid, W + int'(PAR));
        if (PAR) chk("f1011_parity", last_x, 1'b1);

        clr_obs();
        go(4'b0110);
        cyc(W + 3);
        chk("f0110_lsb_rx", rx_l, 4'b0110);
        chk("f0110_msb_rx", rx_m, 4'b0110);

        clr_obs();
        go(4'b1111);
        cyc(1);
        load = 1'b1; din = 4'b0000;
        cyc(1);
        load = 1'b0;
        cyc(W + 3);
        chk("busy_rx", rx_m, 4'b1111);
        chk("busy_done_cnt", ndone, 1);

        clr_obs();
        go(4'b1010);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("abort_valid", v_m, 1'b0);
        chk("abort_ready", rdy_m, 1'b1);
        cyc(W + 2);
        chk("abort_done_cnt", ndone, 0);
        clr_obs();
        go(4'b0101);
        cyc(W + 3);
        chk("after_abort_rx", rx_m, 4'b0101);
        chk("after_abort_done", ndone, 1);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            load = ($urandom_range(2) == 0);
            din = W'($urandom);
            reset = ($urandom_range(99) == 0);
        end
        @(negedge clk);
        load = 1'b0; reset = 1'b0;
        cyc(W + 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
- Parallel-in, serial-out shift transmitter; WIDTH-bit word in, one bit per clock out on x.
- Drives the serial x input of the team's serial-in/parallel-out shift receiver (4-bit default), so a word loaded here reappears on the receiver's out.
- Simple load/ready handshake on the parallel side; bit-valid and end-of-frame pulse on the serial side.

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = shift out din[WIDTH-1] first; 0 = din[0] first.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  request to accept din; honoured only when ready=1.
- din  input  WIDTH  parallel word, sampled on the accepting edge.
- ready  output  1  1 = idle, able to accept a load.
- x  output  1  serial data bit.
- valid  output  1  1 = x carries a frame bit this cycle.
- done  output  1  single-cycle pulse coincident with the final bit of a frame.

Behaviour:
- All outputs are registered. Reset values: ready=1, x=0, valid=0, done=0, shift register=0, bit counter=0, state=IDLE.
- FSM states: IDLE and SHIFT (PARITY is added under the optional feature).
- IDLE: ready=1, valid=0, x=0. On an edge with load=1:
  - capture din;
  - go to SHIFT;
  - the first bit appears on x with valid=1 in the next cycle (latency 1 cycle from load).
- SHIFT:
  - valid=1 and ready=0 for exactly WIDTH consecutive cycles.
  - Bit order follows MSB_FIRST.
  - The counter runs 0..WIDTH-1 and has width $clog2(WIDTH)+1.
  - done=1 only in the cycle carrying bit WIDTH-1.
  - The next edge returns to IDLE: valid=0, x=0, ready=1.
- load while ready=0 is ignored and din is not sampled. A new frame starts only from IDLE, so frames are separated by at least one idle cycle.
- din changes after the accepting edge have no effect on the frame in flight.
- reset has priority over load, including when both are asserted on the same edge.
- reset mid-frame: the next edge aborts the frame and forces the reset values. No done pulse is emitted for the aborted frame.
- No wrap-around: the counter clears on entry to SHIFT and never exceeds WIDTH-1.

Optional Feature:
- Macro: PISO_SHIFT_TX_PARITY_EN.
- Defined:
  - After the last data bit, the FSM enters PARITY for one cycle.
  - x = even parity (XOR of all captured data bits), valid=1.
  - done moves to the parity cycle; the frame is WIDTH+1 valid cycles.
- Undefined: the PARITY state and its logic are absent; frame is WIDTH cycles, done on the last data bit.

Decomposition:
- Shared package piso_pkg:
  - state enum (IDLE, SHIFT, PARITY);
  - default width constant DATA_W=4;
  - function cnt_w(w) returning the counter width.
- One natural sub-module, piso_bit_counter: a clear/enable counter with terminal-count flag at WIDTH-1, reusable by the receiver for its word-complete flag.
- The FSM and shift register stay in the top module.

Test Plan:
- Reset then idle: reset=1 for 2 edges, then 0 -> ready=1, valid=0, x=0, done=0 every cycle with no load.
- Single frame, WIDTH=4, MSB_FIRST=1: load=1, din=4'b1011 for one edge -> next 4 cycles x=1,0,1,1 with valid=1; done=1 on the 4th; ready=1 the following cycle.
- LSB first: MSB_FIRST=0, din=4'b0110 -> x=0,1,1,0; loopback into the shift receiver yields receiver out=4'b0110 after the frame.
- Load while busy: second load with din=4'b0000 during bit 2 of a 4'b1111 frame -> ignored; x stays 1,1,1,1; a single done pulse.
- Reset mid-frame: reset=1 during bit 1 of din=4'b1010 -> next edge valid=0, x=0, ready=1, no done; a subsequent load of 4'b0101 transmits correctly.
- Parity (macro defined): din=4'b1011 -> x=1,0,1,1 then parity bit 1; valid for 5 cycles; done on the 5th.
